// File: rtl/bambu_mem_model.sv
// rtl/bambu_mem_model.sv - Multi-channel byte-addressed memory responder for Bambu HLS benches
// Optional feature: define MEM_MODEL_TRACE_EN to $display every completed access.
module bambu_mem_model #(
  parameter int CHANNELS     = 2,
  parameter int BITSIZE_DATA = 8,
  parameter int BITSIZE_ADDR = 9,
  parameter int BITSIZE_SIZE = 4,
  parameter int MEMSIZE      = 64,
  parameter int BASE_ADDR    = 0,
  parameter int READ_DELAY   = 2,
  parameter int WRITE_DELAY  = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              Mout_oe_ram,
  input  logic [CHANNELS-1:0]              Mout_we_ram,
  input  logic [CHANNELS*BITSIZE_ADDR-1:0] Mout_addr_ram,
  input  logic [CHANNELS*BITSIZE_DATA-1:0] Mout_Wdata_ram,
  input  logic [CHANNELS*BITSIZE_SIZE-1:0] Mout_data_ram_size,
  input  logic [CHANNELS*BITSIZE_DATA-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]              Sout_DataRdy,
  output logic [CHANNELS*BITSIZE_DATA-1:0] M_Rdata_ram,
  output logic [CHANNELS-1:0]              M_DataRdy,
  output logic [CHANNELS-1:0]              err_conflict,
  output logic                             err_collision
);

  localparam int NBYTES    = BITSIZE_DATA / 8;
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int IDX_W     = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q [CHANNELS];
  state_t                  state_d [CHANNELS];
  logic [CNT_W-1:0]        cnt_q   [CHANNELS];
  logic [BITSIZE_ADDR-1:0] addr_q  [CHANNELS];
  logic [BITSIZE_DATA-1:0] wdata_q [CHANNELS];
  logic [BITSIZE_SIZE-1:0] size_q  [CHANNELS];
  logic [BITSIZE_DATA-1:0] rdata_q [CHANNELS];
  logic [BITSIZE_DATA-1:0] rdata_d [CHANNELS];
  logic [CHANNELS-1:0]     we_q;

  logic [BITSIZE_ADDR-1:0] ch_addr [CHANNELS];
  logic [CHANNELS-1:0]     in_win;
  logic [CHANNELS-1:0]     start;
  logic [CHANNELS-1:0]     conflict_set;
  logic [CHANNELS-1:0]     cur_we;
  logic [CHANNELS-1:0]     conflict_q;
  logic                    collision_q;
  logic                    collision_d;

  // Contents survive reset; only power-up clears them.
  logic [7:0]              mem_q [MEMSIZE] = '{default: 8'h00};
  logic [7:0]              mem_d [MEMSIZE];
  logic [MEMSIZE-1:0]      touched;
  logic [BITSIZE_DATA-1:0] wr_mask;
  longint                  wr_off;
  longint                  rd_off;

  function automatic longint byte_off(input logic [BITSIZE_ADDR-1:0] a, input int b);
    return longint'(a) - longint'(BASE_ADDR) + longint'(b);
  endfunction

  function automatic logic in_range(input longint off);
    return (off >= 0) && (off < longint'(MEMSIZE));
  endfunction

  function automatic logic [BITSIZE_DATA-1:0] wmask(input logic [BITSIZE_SIZE-1:0] s);
    logic [BITSIZE_DATA-1:0] one;
    one = BITSIZE_DATA'(1);
    if (int'(s) >= BITSIZE_DATA) return '1;
    return (one << s) - one;
  endfunction

  function automatic logic [CNT_W-1:0] lat(input logic is_we);
    return is_we ? CNT_W'(WRITE_DELAY) : CNT_W'(READ_DELAY);
  endfunction

  // In IDLE the live request defines the operation; afterwards the captured one does.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_addr[i]      = Mout_addr_ram[i*BITSIZE_ADDR +: BITSIZE_ADDR];
      in_win[i]       = in_range(byte_off(ch_addr[i], 0));
      start[i]        = (state_q[i] == S_IDLE) && in_win[i] && (Mout_oe_ram[i] ^ Mout_we_ram[i]);
      conflict_set[i] = (state_q[i] == S_IDLE) && in_win[i] && Mout_oe_ram[i] && Mout_we_ram[i];
      cur_we[i]       = (state_q[i] == S_IDLE) ? Mout_we_ram[i] : we_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= state_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE: if (start[i]) state_d[i] = (lat(cur_we[i]) == CNT_W'(1)) ? S_DONE : S_BUSY;
        S_BUSY: if (cnt_q[i] + CNT_W'(1) == lat(cur_we[i])) state_d[i] = S_DONE;
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    M_Rdata_ram = Sout_Rdata_ram;
    M_DataRdy   = Sout_DataRdy;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q[i] == S_DONE) begin
        M_DataRdy[i] = 1'b1;
        M_Rdata_ram[i*BITSIZE_DATA +: BITSIZE_DATA] =
          rdata_q[i] | Sout_Rdata_ram[i*BITSIZE_DATA +: BITSIZE_DATA];
      end
    end
  end

  assign err_conflict  = conflict_q;
  assign err_collision = collision_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]   <= '0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        size_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
      we_q        <= '0;
      conflict_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (start[i]) begin
          addr_q[i]  <= ch_addr[i];
          wdata_q[i] <= Mout_Wdata_ram[i*BITSIZE_DATA +: BITSIZE_DATA];
          size_q[i]  <= Mout_data_ram_size[i*BITSIZE_SIZE +: BITSIZE_SIZE];
          we_q[i]    <= Mout_we_ram[i];
          cnt_q[i]   <= CNT_W'(1);
        end else if (state_q[i] == S_BUSY) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (state_q[i] == S_DONE) begin
          cnt_q[i] <= '0;
        end
        if (state_d[i] == S_DONE && state_q[i] != S_DONE)
          rdata_q[i] <= cur_we[i] ? '0 : rdata_d[i];
      end
      conflict_q  <= conflict_q | conflict_set;
      collision_q <= collision_q | collision_d;
    end
  end

  // Sampled from the pre-edge array, so a same-edge commit is not visible.
  always_comb begin
    rd_off = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      rdata_d[i] = '0;
      for (int b = 0; b < NBYTES; b++) begin
        rd_off = byte_off((state_q[i] == S_IDLE) ? ch_addr[i] : addr_q[i], b);
        if (in_range(rd_off)) rdata_d[i][b*8 +: 8] = mem_q[IDX_W'(rd_off)];
      end
    end
  end

  // Later channels overwrite earlier ones, so the highest index wins a shared byte.
  always_comb begin
    mem_d       = mem_q;
    touched     = '0;
    collision_d = 1'b0;
    wr_mask     = '0;
    wr_off      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q[i] == S_DONE && we_q[i]) begin
        wr_mask = wmask(size_q[i]);
        for (int b = 0; b < NBYTES; b++) begin
          wr_off = byte_off(addr_q[i], b);
          if (in_range(wr_off)) begin
            if (touched[IDX_W'(wr_off)]) collision_d = 1'b1;
            touched[IDX_W'(wr_off)] = 1'b1;
            mem_d[IDX_W'(wr_off)] = (wdata_q[i][b*8 +: 8] & wr_mask[b*8 +: 8]) |
                                    (mem_q[IDX_W'(wr_off)] & ~wr_mask[b*8 +: 8]);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef MEM_MODEL_TRACE_EN
  always @(posedge clock) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q[i] == S_DONE)
        $display("%0t ch%0d %s addr=%h mask=%h data=%h", $time, i, we_q[i] ? "W" : "R",
                 addr_q[i], wmask(size_q[i]), we_q[i] ? wdata_q[i] : rdata_q[i]);
    end
  end
`else
`endif

endmodule

// File: tb/tb_bambu_mem_model.sv
// tb/tb_bambu_mem_model.sv - Directed self-checking bench for bambu_mem_model
module tb_bambu_mem_model;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Default parameters
  logic [1:0]  oe_a, we_a, s_rdy_a, rdy_a, conflict_a;
  logic [17:0] addr_a;
  logic [15:0] wdata_a, s_rdata_a, rdata_a;
  logic [7:0]  size_a;
  logic        collision_a;

  // Window moved to 0x40
  logic [1:0]  oe_b, we_b, s_rdy_b, rdy_b, conflict_b;
  logic [17:0] addr_b;
  logic [15:0] wdata_b, s_rdata_b, rdata_b;
  logic [7:0]  size_b;
  logic        collision_b;

  // Four 16-bit channels, read latency 3
  logic [3:0]  oe_w, we_w, s_rdy_w, rdy_w, conflict_w;
  logic [35:0] addr_w;
  logic [63:0] wdata_w, s_rdata_w, rdata_w;
  logic [19:0] size_w;
  logic        collision_w;

  bambu_mem_model u_dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe_a), .Mout_we_ram(we_a), .Mout_addr_ram(addr_a),
    .Mout_Wdata_ram(wdata_a), .Mout_data_ram_size(size_a),
    .Sout_Rdata_ram(s_rdata_a), .Sout_DataRdy(s_rdy_a),
    .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
    .err_conflict(conflict_a), .err_collision(collision_a)
  );

  bambu_mem_model #(.BASE_ADDR(9'h040)) u_win (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe_b), .Mout_we_ram(we_b), .Mout_addr_ram(addr_b),
    .Mout_Wdata_ram(wdata_b), .Mout_data_ram_size(size_b),
    .Sout_Rdata_ram(s_rdata_b), .Sout_DataRdy(s_rdy_b),
    .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
    .err_conflict(conflict_b), .err_collision(collision_b)
  );

  bambu_mem_model #(.CHANNELS(4), .BITSIZE_DATA(16), .BITSIZE_SIZE(5), .READ_DELAY(3)) u_wide (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe_w), .Mout_we_ram(we_w), .Mout_addr_ram(addr_w),
    .Mout_Wdata_ram(wdata_w), .Mout_data_ram_size(size_w),
    .Sout_Rdata_ram(s_rdata_w), .Sout_DataRdy(s_rdy_w),
    .M_Rdata_ram(rdata_w), .M_DataRdy(rdy_w),
    .err_conflict(conflict_w), .err_collision(collision_w)
  );

  task automatic idle_all();
    oe_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; size_a = '0; s_rdata_a = '0; s_rdy_a = '0;
    oe_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; size_b = '0; s_rdata_b = '0; s_rdy_b = '0;
    oe_w = '0; we_w = '0; addr_w = '0; wdata_w = '0; size_w = '0; s_rdata_w = '0; s_rdy_w = '0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic req_a(input int ch, input logic r, input logic w, input logic [8:0] a,
                       input logic [7:0] d, input logic [3:0] s);
    oe_a[ch] = r; we_a[ch] = w;
    addr_a[ch*9 +: 9] = a; wdata_a[ch*8 +: 8] = d; size_a[ch*4 +: 4] = s;
  endtask

  task automatic req_b(input int ch, input logic r, input logic w, input logic [8:0] a,
                       input logic [7:0] d, input logic [3:0] s);
    oe_b[ch] = r; we_b[ch] = w;
    addr_b[ch*9 +: 9] = a; wdata_b[ch*8 +: 8] = d; size_b[ch*4 +: 4] = s;
  endtask

  task automatic req_w(input int ch, input logic r, input logic w, input logic [8:0] a,
                       input logic [15:0] d, input logic [4:0] s);
    oe_w[ch] = r; we_w[ch] = w;
    addr_w[ch*9 +: 9] = a; wdata_w[ch*16 +: 16] = d; size_w[ch*5 +: 5] = s;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_all();
    cyc(2);
    n_tests++;
    if ({rdy_a, rdata_a, conflict_a, collision_a} !== 21'h0) begin
      n_fail++; $display("FAIL reset_default: got %h expected 0", {rdy_a, rdata_a, conflict_a, collision_a});
    end
    n_tests++;
    if ({rdy_b, rdata_b, conflict_b, collision_b} !== 21'h0) begin
      n_fail++; $display("FAIL reset_window: got %h expected 0", {rdy_b, rdata_b, conflict_b, collision_b});
    end
    n_tests++;
    if ({rdy_w, rdata_w, conflict_w, collision_w} !== 73'h0) begin
      n_fail++; $display("FAIL reset_wide: got %h expected 0", {rdy_w, rdata_w, conflict_w, collision_w});
    end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_write_read();
    req_a(0, 1'b0, 1'b1, 9'd5, 8'hA5, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if (rdy_a !== 2'b01) begin n_fail++; $display("FAIL wr_rdy_t1: got %b expected 01", rdy_a); end
    cyc(1);
    n_tests++;
    if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL wr_rdy_pulse: got %b expected 00", rdy_a); end
    req_a(0, 1'b1, 1'b0, 9'd5, 8'h00, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if ({rdy_a, rdata_a} !== 18'h0) begin n_fail++; $display("FAIL rd_busy: got %h expected 0", {rdy_a, rdata_a}); end
    cyc(1);
    n_tests++;
    if ({rdy_a, rdata_a[7:0]} !== {2'b01, 8'hA5}) begin
      n_fail++; $display("FAIL rd_data: got %h expected %h", {rdy_a, rdata_a[7:0]}, {2'b01, 8'hA5});
    end
    cyc(1);
  endtask

  task automatic test_partial();
    req_a(0, 1'b0, 1'b1, 9'd3, 8'hFF, 4'd8);
    cyc(1); idle_all(); cyc(1);
    req_a(0, 1'b0, 1'b1, 9'd3, 8'h00, 4'd4);
    cyc(1); idle_all(); cyc(1);
    req_a(0, 1'b1, 1'b0, 9'd3, 8'h00, 4'd0);
    req_a(1, 1'b1, 1'b0, 9'd4, 8'h00, 4'd0);
    cyc(2); idle_all();
    n_tests++;
    if ({rdy_a, rdata_a} !== {2'b11, 16'h00F0}) begin
      n_fail++; $display("FAIL partial_wr: got %h expected %h", {rdy_a, rdata_a}, {2'b11, 16'h00F0});
    end
    cyc(1);
  endtask

  task automatic test_back_to_back();
    req_a(0, 1'b0, 1'b1, 9'd20, 8'h77, 4'd8);
    req_a(1, 1'b1, 1'b0, 9'd20, 8'h00, 4'd0);
    cyc(1); idle_all();
    n_tests++;
    if (rdy_a !== 2'b01) begin n_fail++; $display("FAIL b2b_wr_done: got %b expected 01", rdy_a); end
    cyc(1);
    n_tests++;
    if ({rdy_a, rdata_a} !== {2'b10, 16'h0000}) begin
      n_fail++; $display("FAIL b2b_same_edge: got %h expected %h", {rdy_a, rdata_a}, {2'b10, 16'h0000});
    end
    cyc(1);
    req_a(1, 1'b1, 1'b0, 9'd20, 8'h00, 4'd0);
    cyc(2); idle_all();
    n_tests++;
    if ({rdy_a, rdata_a} !== {2'b10, 16'h7700}) begin
      n_fail++; $display("FAIL b2b_later_read: got %h expected %h", {rdy_a, rdata_a}, {2'b10, 16'h7700});
    end
    cyc(1);
  endtask

  task automatic test_conflict();
    req_a(0, 1'b1, 1'b1, 9'd10, 8'h33, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if ({conflict_a, rdy_a} !== 4'b0100) begin
      n_fail++; $display("FAIL conflict_set: got %b expected 0100", {conflict_a, rdy_a});
    end
    cyc(1);
    n_tests++;
    if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL conflict_ignored: got %b expected 00", rdy_a); end
    cyc(2);
    n_tests++;
    if (conflict_a !== 2'b01) begin n_fail++; $display("FAIL conflict_sticky: got %b expected 01", conflict_a); end
  endtask

  task automatic test_collision();
    req_a(0, 1'b0, 1'b1, 9'd7, 8'h11, 4'd8);
    req_a(1, 1'b0, 1'b1, 9'd7, 8'h22, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if ({rdy_a, collision_a} !== 3'b110) begin
      n_fail++; $display("FAIL coll_done: got %b expected 110", {rdy_a, collision_a});
    end
    cyc(1);
    n_tests++;
    if (collision_a !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b expected 1", collision_a); end
    req_a(0, 1'b1, 1'b0, 9'd7, 8'h00, 4'd0);
    req_a(1, 1'b1, 1'b0, 9'd10, 8'h00, 4'd0);
    cyc(2); idle_all();
    n_tests++;
    if ({rdy_a, rdata_a} !== {2'b11, 16'h0022}) begin
      n_fail++; $display("FAIL coll_winner: got %h expected %h", {rdy_a, rdata_a}, {2'b11, 16'h0022});
    end
    cyc(1);
  endtask

  task automatic test_reset_abort();
    req_a(0, 1'b1, 1'b0, 9'd7, 8'h00, 4'd0);
    req_a(1, 1'b0, 1'b1, 9'd7, 8'h55, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if (rdy_a !== 2'b10) begin n_fail++; $display("FAIL abort_pre: got %b expected 10", rdy_a); end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({rdy_a, conflict_a, collision_a} !== 5'b0) begin
      n_fail++; $display("FAIL abort_flags: got %b expected 00000", {rdy_a, conflict_a, collision_a});
    end
    cyc(2);
    n_tests++;
    if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL abort_no_rdy: got %b expected 00", rdy_a); end
    reset = 1'b1;
    cyc(1);
    req_a(0, 1'b1, 1'b0, 9'd7, 8'h00, 4'd0);
    cyc(2); idle_all();
    n_tests++;
    if ({rdy_a, rdata_a[7:0]} !== {2'b01, 8'h22}) begin
      n_fail++; $display("FAIL abort_mem_kept: got %h expected %h", {rdy_a, rdata_a[7:0]}, {2'b01, 8'h22});
    end
    cyc(1);
  endtask

  task automatic test_window();
    req_b(1, 1'b1, 1'b0, 9'h010, 8'h00, 4'd0);
    s_rdy_b = 2'b10; s_rdata_b = 16'h3C00;
    #1;
    n_tests++;
    if ({rdy_b, rdata_b} !== {2'b10, 16'h3C00}) begin
      n_fail++; $display("FAIL oow_passthru: got %h expected %h", {rdy_b, rdata_b}, {2'b10, 16'h3C00});
    end
    cyc(1); idle_all();
    cyc(1);
    n_tests++;
    if (rdy_b !== 2'b00) begin n_fail++; $display("FAIL oow_stays_idle: got %b expected 00", rdy_b); end
    req_b(0, 1'b0, 1'b1, 9'h07F, 8'h5A, 4'd8);
    req_b(1, 1'b0, 1'b1, 9'h080, 8'hC3, 4'd8);
    cyc(1); idle_all();
    n_tests++;
    if (rdy_b !== 2'b01) begin n_fail++; $display("FAIL win_edge_wr: got %b expected 01", rdy_b); end
    cyc(1);
    req_b(0, 1'b1, 1'b0, 9'h07F, 8'h00, 4'd0);
    req_b(1, 1'b1, 1'b0, 9'h040, 8'h00, 4'd0);
    cyc(2); idle_all();
    n_tests++;
    if ({rdy_b, rdata_b} !== {2'b11, 16'h005A}) begin
      n_fail++; $display("FAIL win_edge_rd: got %h expected %h", {rdy_b, rdata_b}, {2'b11, 16'h005A});
    end
    cyc(1);
  endtask

  task automatic test_wide();
    req_w(0, 1'b0, 1'b1, 9'd0,  16'h2211, 5'd16);
    req_w(1, 1'b0, 1'b1, 9'd2,  16'h4433, 5'd16);
    req_w(2, 1'b0, 1'b1, 9'd4,  16'h6655, 5'd8);
    req_w(3, 1'b0, 1'b1, 9'd63, 16'hBBAA, 5'd16);
    cyc(1); idle_all();
    n_tests++;
    if (rdy_w !== 4'hF) begin n_fail++; $display("FAIL wide_wr_done: got %h expected F", rdy_w); end
    cyc(1);
    n_tests++;
    if (collision_w !== 1'b0) begin n_fail++; $display("FAIL wide_no_coll: got %b expected 0", collision_w); end
    req_w(0, 1'b1, 1'b0, 9'd1,  16'h0, 5'd0);
    req_w(1, 1'b1, 1'b0, 9'd4,  16'h0, 5'd0);
    req_w(2, 1'b1, 1'b0, 9'd63, 16'h0, 5'd0);
    req_w(3, 1'b1, 1'b0, 9'd0,  16'h0, 5'd0);
    cyc(2); idle_all();
    n_tests++;
    if (rdy_w !== 4'h0) begin n_fail++; $display("FAIL wide_busy: got %h expected 0", rdy_w); end
    cyc(1);
    n_tests++;
    if ({rdy_w, rdata_w} !== {4'hF, 64'h2211_00AA_0055_3322}) begin
      n_fail++; $display("FAIL wide_rd: got %h expected %h", {rdy_w, rdata_w}, {4'hF, 64'h2211_00AA_0055_3322});
    end
    cyc(1);
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_partial();
    test_back_to_back();
    test_conflict();
    test_collision();
    test_reset_abort();
    test_window();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bambu_mem_model.md
# bambu_mem_model

Parametrised multi-channel off-chip memory responder for Bambu HLS simulation benches. It sits between a generated `main` top and the bench, and serves its master memory ports (`Mout_*`) from a byte-addressed array. Each channel has a programmable read and write latency, a size-masked partial write, and out-of-window pass-through of the slave return bus (`Sout_*`). Conflicting requests on a channel and colliding writes across channels raise sticky error flags.

## Interface
Parameters:
- CHANNELS, 2: number of independent memory channels.
- BITSIZE_DATA, 8: data width per channel. Must be a multiple of 8.
- BITSIZE_ADDR, 9: address width per channel, in bytes.
- BITSIZE_SIZE, 4: width of the per-channel access size field, in bits.
- MEMSIZE, 64: array size in bytes.
- BASE_ADDR, 0: byte address of array entry 0.
- READ_DELAY, 2: read latency in cycles. Must be at least 1.
- WRITE_DELAY, 1: write latency in cycles. Must be at least 1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Mout_oe_ram  in  CHANNELS  read request, one bit per channel.
- Mout_we_ram  in  CHANNELS  write request, one bit per channel.
- Mout_addr_ram  in  CHANNELS*BITSIZE_ADDR  byte address; channel i occupies slice i.
- Mout_Wdata_ram  in  CHANNELS*BITSIZE_DATA  write data.
- Mout_data_ram_size  in  CHANNELS*BITSIZE_SIZE  access size in bits.
- Sout_Rdata_ram  in  CHANNELS*BITSIZE_DATA  slave read data, ORed into the output.
- Sout_DataRdy  in  CHANNELS  slave ready, ORed into the output.
- M_Rdata_ram  out  CHANNELS*BITSIZE_DATA  read data returned to the master.
- M_DataRdy  out  CHANNELS  one-cycle completion strobe.
- err_conflict  out  CHANNELS  sticky: oe and we were both high on the channel in the same cycle.
- err_collision  out  1  sticky: two channels committed to the same byte in one cycle.

## Operation
- In window: BASE_ADDR <= addr < BASE_ADDR+MEMSIZE. Requests outside the window are ignored. For those channels M_Rdata_ram = Sout_Rdata_ram and M_DataRdy = Sout_DataRdy.
- Per-channel FSM:
  - IDLE: an in-window oe or we captures op, addr, wdata and size, loads cnt=1 and moves to BUSY. If both oe and we are high, err_conflict[i] sets and the request is ignored.
  - BUSY: cnt increments each cycle. When cnt reaches L (READ_DELAY or WRITE_DELAY), the FSM moves to DONE.
  - DONE: M_DataRdy[i]=1 for exactly this cycle; any request present is ignored; next state is IDLE.
- Only the captured values are used. Master changes to inputs while the channel is BUSY or DONE have no effect.
- Access span: BITSIZE_DATA/8 consecutive bytes, little-endian, starting at the captured address. Bytes beyond MEMSIZE-1 read as 0 and are never written.
- Write mask: if size >= BITSIZE_DATA, all ones; otherwise (1<<size)-1. Each byte becomes (wdata & mask) | (old & ~mask).
- Read data is sampled from the array on the edge that enters DONE. It is held in a register and driven only while in DONE, and is 0 otherwise. The value is ORed with Sout_Rdata_ram.
- Write commit happens on the edge that leaves DONE.
- Cross-channel byte overlap in one commit: the higher channel index wins and err_collision sets.
- Read/write ordering: a read sees every commit made on earlier edges. It does not see a commit on the same edge as its sample.
- Array contents are initialised to 0 at time 0. Reset does not clear them.

## Timing
- Reset (asynchronous, low), all outputs: M_DataRdy=0, M_Rdata_ram=0, err_conflict=0, err_collision=0. All FSMs go to IDLE and cnt=0. Reset asserted mid-access aborts the access and no commit happens.
- Latency: a request seen in IDLE in cycle T gives M_DataRdy high in cycle T+L.
- Throughput: at most one access per L+1 cycles per channel.
- Channels run independently; simultaneous activity on all channels is legal.
- err flags clear only on reset.

## Configuration
- MEM_MODEL_TRACE_EN defined: on every DONE cycle the block $displays `$time`, channel, R/W, address, mask and data.
- MEM_MODEL_TRACE_EN undefined: no simulation output and no extra logic; behaviour is otherwise identical.

## Test plan
- Write then read, defaults (BASE_ADDR=0): ch0 we, addr 5, wdata 0xA5, size 8 → DataRdy at T+1, mem[5]=0xA5. Then ch0 oe, addr 5 → DataRdy at T+2 with M_Rdata_ram[7:0]=0xA5.
- Partial write: mem[3]=0xFF, then write 0x00 with size 4 → mem[3]=0xF0.
- Out of window, BASE_ADDR=0x40: ch1 oe at addr 0x10 with Sout_DataRdy[1]=1 and Sout_Rdata=0x3C → M_DataRdy[1]=1 and M_Rdata=0x3C the same cycle; FSM stays IDLE.
- Collision: ch0 writes 0x11 and ch1 writes 0x22 to addr 7, same cycle, WRITE_DELAY=1 → mem[7]=0x22, err_collision=1.
- Conflict plus reset: oe and we both high on ch0 → err_conflict[0]=1. A read in BUSY cut by reset low → no DataRdy, flags 0, memory unchanged.
- CHANNELS=4, BITSIZE_DATA=16, READ_DELAY=3: reads on all channels in the same cycle → four DataRdy strobes at T+3 with correct little-endian data.
